// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int FQ_PC_W  = 9;
    localparam int FQ_INS_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    typedef struct packed {
        logic [FQ_PC_W-1:0]  pc;
        logic [FQ_INS_W-1:0] instr;
        logic                filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at issue, filled in
// response order, and popped from the head once filled.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alloc,
    input  logic [FQ_PC_W-1:0]  alloc_pc,
    input  logic                fill,
    input  logic [FQ_INS_W-1:0] fill_data,
    input  logic                pop,
    input  logic                flush,
    output logic [AW:0]         count,
    output logic [AW:0]         unfilled,
    output fq_entry_t           head,
    output logic                head_valid
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    fq_entry_t   mem [DEPTH];
    logic [AW:0] hd;
    logic [AW:0] tl;
    logic [AW:0] fp;

    // Pointers carry an extra wrap bit so full and empty differ.
    assign count      = tl - hd;
    assign unfilled   = tl - fp;
    assign head       = mem[hd[AW-1:0]];
    assign head_valid = (count != '0) && head.filled;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hd <= '0;
            tl <= '0;
            fp <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            hd <= '0;
            tl <= '0;
            fp <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i].filled <= 1'b0;
        end else begin
            if (alloc && count != FULL) begin
                mem[tl[AW-1:0]].pc     <= alloc_pc;
                mem[tl[AW-1:0]].filled <= 1'b0;
                tl <= tl + 1'b1;
            end
            if (fill && unfilled != '0) begin
                mem[fp[AW-1:0]].instr  <= fill_data;
                mem[fp[AW-1:0]].filled <= 1'b1;
                fp <= fp + 1'b1;
            end
            if (pop && head_valid) begin
                mem[hd[AW-1:0]].filled <= 1'b0;
                hd <= hd + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the fetch PC, issues memory requests, and drops
// responses that belong to the epoch before a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W     = FQ_PC_W,
    parameter int INS_W    = FQ_INS_W,
    parameter int FQ_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             stall,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [PC_W-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [INS_W-1:0] imem_rsp_data,
    output logic             if_valid,
    output logic [PC_W-1:0]  if_pc,
    output logic [INS_W-1:0] if_instr
);

    localparam int AW = $clog2(FQ_DEPTH);
    localparam int DW = $clog2(FQ_DEPTH + 1);
    localparam logic [AW:0] FULL = (AW+1)'(FQ_DEPTH);

    logic [PC_W-1:0] fetch_pc;
    logic [DW-1:0]   drop_cnt;
    logic [DW-1:0]   drop_sum;
    logic [DW-1:0]   drop_next;
    logic [AW:0]     count;
    logic [AW:0]     unfilled;
    fq_entry_t       head;
    logic            head_valid;
    logic            issue;
    logic            fill;
    logic            pop;

    assign imem_req_valid = !reset && !redirect_valid
                          && (count < FULL);
    assign imem_req_addr  = fetch_pc;
    assign issue = imem_req_valid && imem_req_ready;
    assign fill  = imem_rsp_valid && !redirect_valid
                 && (drop_cnt == '0);
    assign pop   = head_valid && !stall && !redirect_valid;

    // A response in the redirect cycle belongs to the old epoch.
    assign drop_sum  = DW'(unfilled) + drop_cnt;
    assign drop_next = (imem_rsp_valid && drop_sum != '0)
                     ? drop_sum - 1'b1 : drop_sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            drop_cnt <= drop_next;
        end else begin
            if (issue)
                fetch_pc <= fetch_pc + PC_W'(4);
            if (imem_rsp_valid && drop_cnt != '0)
                drop_cnt <= drop_cnt - 1'b1;
        end
    end

    fetch_queue #(
        .DEPTH(FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .alloc     (issue),
        .alloc_pc  (fetch_pc),
        .fill      (fill),
        .fill_data (imem_rsp_data),
        .pop       (pop),
        .flush     (redirect_valid),
        .count     (count),
        .unfilled  (unfilled),
        .head      (head),
        .head_valid(head_valid)
    );

    assign if_valid = head_valid;
    assign if_pc    = head_valid ? head.pc : '0;
    assign if_instr = head_valid ? head.instr : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int D = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [8:0]  redirect_pc = '0;
    logic        stall = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [8:0]  imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        if_valid;
    logic [8:0]  if_pc;
    logic [31:0] if_instr;

    fetch_unit #(
        .PC_W(9), .INS_W(32), .FQ_DEPTH(D), .RESET_PC(9'h000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .stall         (stall),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: program-order queue of {pc, instr, filled}.
    typedef struct {
        logic [8:0]  pc;
        logic [31:0] instr;
        bit          filled;
    } ment_t;
    ment_t      mq[$];
    logic [8:0] m_pc;
    int         m_drop;

    // Memory model: in-order pending requests with due cycle.
    typedef struct {
        logic [8:0] addr;
        int         due;
    } preq_t;
    preq_t pend[$];
    int    last_due;

    int         lat = 1;
    bit         k_ready, k_stall, k_redir, rand_mode;
    logic [8:0] k_rpc;
    bit         redir_on_rsp, redir_hit;

    logic [8:0]  dpc[$];
    int          dcyc[$];
    logic [31:0] dins[$];
    logic [8:0]  acc[$];
    logic        s_if_valid, s_req_valid;
    logic [8:0]  s_req_addr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h cyc=%0d",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [8:0] a);
        return {23'h0, a} | 32'h100;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc = 9'h000;
        m_drop = 0;
        pend.delete();
        last_due = -1;
    endtask

    task automatic cycle();
        bit exp_req, exp_if, do_pop;
        int unf, idx, l;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data = mk(pend[0].addr);
        end
        if (rand_mode) begin
            k_stall = ($urandom_range(0, 99) < 30);
            k_ready = ($urandom_range(0, 99) < 70);
            k_redir = ($urandom_range(0, 99) < 5);
            k_rpc = {7'($urandom_range(0, 127)), 2'b00};
        end
        stall = k_stall;
        redirect_valid = k_redir;
        redirect_pc = k_rpc;
        imem_req_ready = k_ready && (pend.size() < D);
        if (redir_on_rsp && imem_rsp_valid) begin
            redirect_valid = 1'b1;
            stall = 1'b1;
            redir_on_rsp = 1'b0;
            redir_hit = 1'b1;
        end
        #1;
        exp_req = !redirect_valid && (mq.size() < D);
        exp_if = (mq.size() > 0) && mq[0].filled;
        chk("req_valid", 32'(imem_req_valid), 32'(exp_req));
        if (exp_req)
            chk("req_addr", 32'(imem_req_addr), 32'(m_pc));
        chk("if_valid", 32'(if_valid), 32'(exp_if));
        if (exp_if) begin
            chk("if_pc", 32'(if_pc), 32'(mq[0].pc));
            chk("if_instr", if_instr, mq[0].instr);
        end else begin
            chk("if_instr_nop", if_instr, NOP_INSTR);
        end
        s_if_valid = if_valid;
        s_req_valid = imem_req_valid;
        s_req_addr = imem_req_addr;
        if (if_valid) begin
            dpc.push_back(if_pc);
            dcyc.push_back(cyc);
            dins.push_back(if_instr);
        end
        @(posedge clk);
        if (imem_rsp_valid)
            void'(pend.pop_front());
        if (imem_req_valid && imem_req_ready) begin
            l = rand_mode ? int'($urandom_range(1, 4)) : lat;
            last_due = (cyc + l > last_due + 1) ? cyc + l
                                                : last_due + 1;
            pend.push_back('{addr: imem_req_addr, due: last_due});
            acc.push_back(imem_req_addr);
        end
        if (redirect_valid) begin
            unf = 0;
            foreach (mq[i]) if (!mq[i].filled) unf++;
            m_drop = unf + m_drop - (imem_rsp_valid ? 1 : 0);
            if (m_drop < 0) begin
                chk("protocol_rsp", 32'(1), 32'(0));
                m_drop = 0;
            end
            mq.delete();
            m_pc = redirect_pc;
        end else begin
            do_pop = exp_if && !stall;
            if (imem_rsp_valid) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    idx = -1;
                    foreach (mq[i])
                        if (idx < 0 && !mq[i].filled) idx = i;
                    if (idx < 0) begin
                        chk("protocol_rsp", 32'(1), 32'(0));
                    end else begin
                        mq[idx].instr = imem_rsp_data;
                        mq[idx].filled = 1'b1;
                    end
                end
            end
            if (do_pop)
                void'(mq.pop_front());
            if (exp_req && imem_req_ready) begin
                mq.push_back('{pc: m_pc, instr: '0, filled: 1'b0});
                m_pc = m_pc + 9'd4;
            end
        end
        cyc++;
    endtask

    // Reset is asserted between clock edges to exercise its async path.
    task automatic do_reset(input int hold);
        @(negedge clk);
        #2;
        reset = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'(0));
        chk("rst_if_valid", 32'(if_valid), 32'(0));
        chk("rst_if_pc", 32'(if_pc), 32'(0));
        chk("rst_if_instr", if_instr, NOP_INSTR);
        model_reset();
        repeat (hold) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int n0, n1, st_last, k;
        bit seen8;
        model_reset();
        k_ready = 1'b1;
        k_stall = 1'b0;
        k_redir = 1'b0;
        k_rpc = '0;
        rand_mode = 1'b0;
        redir_on_rsp = 1'b0;
        redir_hit = 1'b0;
        do_reset(2);

        // Always-ready, 1-cycle memory from RESET_PC.
        dpc.delete(); dcyc.delete(); dins.delete();
        repeat (5) cycle();
        chk("seq0_pc", 32'(dpc[0]), 32'h000);
        chk("seq0_cyc", 32'(dcyc[0]), 32'd2);
        chk("seq0_instr", dins[0], 32'h00000100);
        chk("seq1_pc", 32'(dpc[1]), 32'h004);
        chk("seq1_cyc", 32'(dcyc[1]), 32'd3);

        // Hold 0x008 under stall for three cycles.
        n0 = acc.size();
        k_stall = 1'b1;
        repeat (3) cycle();
        k_stall = 1'b0;
        chk("stall_issue_max", 32'(acc.size() - n0 <= D), 32'd1);
        chk("stall_pc_a", 32'(dpc[dpc.size()-3]), 32'h008);
        chk("stall_pc_b", 32'(dpc[dpc.size()-1]), 32'h008);
        chk("stall_instr", dins[dins.size()-1], 32'h00000108);
        n1 = dpc.size();
        st_last = dcyc[n1-1];
        repeat (3) cycle();
        chk("post_stall_pc", 32'(dpc[n1]), 32'h008);
        chk("post_stall_next", 32'(dpc[n1+1]), 32'h00C);
        chk("post_stall_gap", 32'(dcyc[n1+1] - st_last), 32'd2);

        // Memory not ready: nothing allocated, queue drains.
        n0 = acc.size();
        k_ready = 1'b0;
        repeat (4) cycle();
        chk("noready_alloc", 32'(acc.size() - n0), 32'd0);
        chk("noready_drain", 32'(s_if_valid), 32'd0);
        k_ready = 1'b1;

        // Redirect with two requests outstanding, 3-cycle memory.
        lat = 3;
        k = 0;
        while (pend.size() != 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("two_outstanding", 32'(pend.size()), 32'd2);
        k_redir = 1'b1;
        k_rpc = 9'h040;
        n0 = dpc.size();
        cycle();
        k_redir = 1'b0;
        repeat (12) cycle();
        chk("redir_first_pc", 32'(dpc[n0]), 32'h040);
        chk("redir_first_ins", dins[n0], 32'h00000140);

        // Redirect coincident with a response while stalled.
        lat = 1;
        k_rpc = 9'h080;
        redir_hit = 1'b0;
        redir_on_rsp = 1'b1;
        k = 0;
        while (!redir_hit && k < 10) begin
            cycle();
            k++;
        end
        chk("rsp_redir_hit", 32'(redir_hit), 32'd1);
        redir_on_rsp = 1'b0;
        cycle();
        chk("rsp_redir_empty", 32'(s_if_valid), 32'd0);
        chk("rsp_redir_req", 32'(s_req_valid), 32'd1);
        chk("rsp_redir_addr", 32'(s_req_addr), 32'h080);
        repeat (4) cycle();

        // PC wrap-around at the top of the address space.
        k_redir = 1'b1;
        k_rpc = 9'h1F8;
        cycle();
        k_redir = 1'b0;
        n0 = acc.size();
        repeat (10) cycle();
        chk("wrap_a0", 32'(acc[n0]), 32'h1F8);
        chk("wrap_a1", 32'(acc[n0+1]), 32'h1FC);
        chk("wrap_a2", 32'(acc[n0+2]), 32'h000);
        chk("wrap_a3", 32'(acc[n0+3]), 32'h004);

        // Mid-stream asynchronous reset.
        do_reset(1);
        n0 = acc.size();
        repeat (3) cycle();
        chk("rst_restart", 32'(acc[n0]), 32'h000);

        // Randomized traffic with one reset in the middle.
        rand_mode = 1'b1;
        repeat (1500) cycle();
        do_reset(1);
        repeat (1500) cycle();
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
